// File: rtl/snake_pkg.sv
// snake_pkg -- shared types and constants for the snake game front end.
// Direction codes are fixed by the game core: left=00, down=01, up=10, right=11.
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_LEFT  = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_UP    = 2'b10,
      DIR_RIGHT = 2'b11
   } dir_t;

   localparam int   NUM_DIR_BTN = 4;
   localparam dir_t DIR_RESET   = DIR_RIGHT;   // game start heading

   // One-hot form of a direction code, bit index equals the code value.
   function automatic logic [NUM_DIR_BTN-1:0] dir_onehot(input dir_t d);
      return NUM_DIR_BTN'(1) << d;
   endfunction

endpackage

// File: rtl/snake_btn_debounce.sv
// snake_btn_debounce -- one raw button: 2-flop synchronizer, counter debouncer
// and rising-edge detect on the debounced level.
// A button held through reset is ignored until it has been seen released.
module snake_btn_debounce
   import snake_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 10000
) (
   input  logic clk,
   input  logic clear_n,
   input  logic btn,
   output logic rise
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             armed;
   logic             stable;
   logic             stable_q;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchronizer, seeded high so a level present at reset release reads as "held".
   always_ff @(posedge clk or negedge clear_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!clear_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

   // Arm the debouncer once a released level has been sampled after reset.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) armed <= 1'b0;
      else if (!sync2) armed <= 1'b1;
   end

   // Debouncer: accept a level change only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (!armed || (sync2 == stable)) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         stable <= sync2;
         cnt    <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Delayed debounced level for edge detection.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) stable_q <= 1'b0;
      else          stable_q <= stable;
   end

   assign rise = stable & ~stable_q;

endmodule

// File: rtl/snake_dir_input.sv
// snake_dir_input -- debounced, priority-resolved direction request for the game core.
// Holds the latest press until the move tick acks it; all outputs are registered.
// Optional build macro SNAKE_DIR_REVERSE_FILTER_EN: discard presses that reverse the
// current heading and pulse dir_reject instead.
module snake_dir_input
   import snake_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 10000
) (
   input  logic       clk,
   input  logic       clear_n,
   input  logic [3:0] btn,
   input  logic       dir_ack,
   output logic       dir_valid,
   output logic [1:0] dir_code,
   output logic [3:0] direction,
   output logic       dir_reject
);

   logic [NUM_DIR_BTN-1:0] rise;
   logic                   win_vld;
   dir_t                   win_code;
   logic                   is_reverse;
   logic                   accept;
   logic                   reject_d;
   logic                   valid_q;
   logic                   valid_d;
   dir_t                   code_q;
   dir_t                   code_d;
   logic [3:0]             direction_q;
   logic                   reject_q;

   for (genvar i = 0; i < NUM_DIR_BTN; i++) begin : g_btn
      snake_btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
         .clk    (clk),
         .clear_n(clear_n),
         .btn    (btn[i]),
         .rise   (rise[i])
      );
   end

   // Resolve simultaneous edges: right > left > down > up; losers are dropped.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
      win_vld  = 1'b1;
      win_code = DIR_RIGHT;
      if      (rise[3]) win_code = DIR_RIGHT;
      else if (rise[0]) win_code = DIR_LEFT;
      else if (rise[1]) win_code = DIR_DOWN;
      else if (rise[2]) win_code = DIR_UP;
      else              win_vld  = 1'b0;
   end

`ifdef SNAKE_DIR_REVERSE_FILTER_EN
   // code_q is the pending code when valid, else the last acked one -- the reference either way.
   assign is_reverse = (win_code == dir_t'(~code_q));
`else
   assign is_reverse = 1'b0;
`endif

   assign accept   = win_vld & ~is_reverse;
   assign reject_d = win_vld &  is_reverse;

   // Request register next state: an accepted press beats a same-cycle ack.
   always_comb begin
      valid_d = valid_q;
      code_d  = code_q;
      if (accept) begin
         valid_d = 1'b1;
         code_d  = win_code;
      end else if (dir_ack) begin
         valid_d = 1'b0;
      end
   end

   // Registered request state and outputs.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         valid_q     <= 1'b0;
         code_q      <= DIR_RESET;
         direction_q <= '0;
         reject_q    <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         code_q      <= code_d;
         direction_q <= valid_d ? dir_onehot(code_d) : 4'b0000;
         reject_q    <= reject_d;
      end
   end

   assign dir_valid  = valid_q;
   assign dir_code   = code_q;
   assign direction  = direction_q;
   assign dir_reject = reject_q;

endmodule

// File: tb/tb_snake_dir_input.sv
// tb_snake_dir_input -- directed and randomized bench for snake_dir_input with a
// run-length reference model of the button front end and a request model.
`timescale 1ns/1ps
module tb_snake_dir_input;

   localparam int D = 4;
`ifdef SNAKE_DIR_REVERSE_FILTER_EN
   localparam bit FILTER = 1'b1;
`else
   localparam bit FILTER = 1'b0;
`endif

   logic       clk     = 1'b0;
   logic       clear_n = 1'b0;
   logic [3:0] btn     = 4'b0000;
   logic       dir_ack = 1'b0;
   logic       dir_valid;
   logic [1:0] dir_code;
   logic [3:0] direction;
   logic       dir_reject;

   snake_dir_input #(.DEBOUNCE_CYCLES(D)) dut (
      .clk       (clk),
      .clear_n   (clear_n),
      .btn       (btn),
      .dir_ack   (dir_ack),
      .dir_valid (dir_valid),
      .dir_code  (dir_code),
      .direction (direction),
      .dir_reject(dir_reject)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // Request side
   bit       m_valid;
   bit [1:0] m_code;
   bit       m_reject;
   bit [3:0] m_rise;
   // Button side: 2-sample input latency, then a run-length view of each button.
   bit [3:0] pipe0, pipe1;
   bit [3:0] seen_low;   // a released sample has been observed since reset
   bit [3:0] deb;
   bit [3:0] run_val;
   int       run_len[4];
   int       prio[4] = '{3, 0, 1, 2};   // right, left, down, up (index == code)

   function automatic void model_reset();
      m_valid  = 1'b0;
      m_code   = 2'b11;
      m_reject = 1'b0;
      m_rise   = '0;
      pipe0    = 4'hF;
      pipe1    = 4'hF;
      seen_low = '0;
      deb      = '0;
      run_val  = 4'hF;
      for (int i = 0; i < 4; i++) run_len[i] = 0;
   endfunction

   function automatic void model_edge(input bit [3:0] b, input bit a);
      bit       acc;
      bit [3:0] nr;
      bit [1:0] w;
      int       win;
      acc      = 1'b0;
      m_reject = 1'b0;
      win      = -1;
      for (int k = 0; k < 4; k++)
         if (win < 0 && m_rise[prio[k]]) win = prio[k];
      if (win >= 0) begin
         w = 2'(win);
         if (FILTER && (w == ~m_code)) m_reject = 1'b1;
         else begin
            m_code  = w;
            m_valid = 1'b1;
            acc     = 1'b1;
         end
      end
      if (!acc && a) m_valid = 1'b0;

      nr = '0;
      for (int i = 0; i < 4; i++) begin
         bit s, was_seen;
         s        = pipe1[i];
         pipe1[i] = pipe0[i];
         pipe0[i] = b[i];
         was_seen = seen_low[i];
         if (!s) seen_low[i] = 1'b1;
         if (s == run_val[i]) run_len[i]++;
         else begin
            run_val[i] = s;
            run_len[i] = 1;
         end
         if (was_seen && run_val[i] != deb[i] && run_len[i] >= D) begin
            deb[i] = run_val[i];
            nr[i]  = deb[i];
         end
      end
      m_rise = nr;
   endfunction

   task automatic compare_outputs(input string tag);
      bit [3:0] e_dir;
      e_dir = m_valid ? 4'(1 << m_code) : 4'b0000;
      check({tag, ".valid"},     dir_valid,  m_valid);
      check({tag, ".code"},      dir_code,   m_code);
      check({tag, ".direction"}, direction,  e_dir);
      check({tag, ".reject"},    dir_reject, m_reject);
   endtask

   // One clock: drive on the falling edge, model the rising edge, sample 1ns later.
   task automatic tick(input bit [3:0] b, input bit a);
      @(negedge clk);
      btn     = b;
      dir_ack = a;
      @(posedge clk);
      model_edge(b, a);
      #1 compare_outputs("cyc");
   endtask

   // Asynchronous reset pulse placed mid-cycle; outputs must drop without a clock edge.
   task automatic pulse_reset();
      #2 clear_n = 1'b0;
      model_reset();
      #1 compare_outputs("rst_async");
      repeat (2) begin
         @(posedge clk);
         #1 compare_outputs("rst_hold");
      end
      #2 clear_n = 1'b1;
   endtask

   int n;
   int rej_cnt;
   bit [3:0] rb;
   int hold;

   initial begin
      model_reset();
      @(posedge clk);
      #1 compare_outputs("por");
      #2 clear_n = 1'b1;

      // Idle after reset
      repeat (10) tick(4'b0000, 1'b0);
      check("idle_valid", dir_valid, 1'b0);
      check("idle_code", dir_code, 2'b11);

      // Down press latency and ack
      n = 0;
      do begin
         tick(4'b0010, 1'b0);
         n++;
      end while (!dir_valid && n < 20);
      check("down_latency", n, D + 3);
      check("down_code", dir_code, 2'b01);
      check("down_direction", direction, 4'b0010);
      repeat (3) tick(4'b0010, 1'b0);
      check("held_still_pending", dir_valid, 1'b1);
      tick(4'b0010, 1'b1);
      check("ack_clears", dir_valid, 1'b0);
      check("ack_keeps_code", dir_code, 2'b01);
      repeat (10) tick(4'b0000, 1'b0);

      // Short glitch on up
      repeat (3) tick(4'b0100, 1'b0);
      repeat (10) tick(4'b0000, 1'b0);
      check("glitch_no_req", dir_valid, 1'b0);

      // All four together: right wins
      repeat (D + 5) tick(4'b1111, 1'b0);
      check("all_code", dir_code, 2'b11);
      tick(4'b1111, 1'b1);
      repeat (10) tick(4'b0000, 1'b0);

      // Left alone after right acked: reversal
      rej_cnt = 0;
      repeat (10) begin
         tick(4'b0001, 1'b0);
         if (dir_reject) rej_cnt++;
      end
`ifdef SNAKE_DIR_REVERSE_FILTER_EN
      check("left_reject_pulses", rej_cnt, 1);
      check("left_rejected_valid", dir_valid, 1'b0);
      check("left_rejected_code", dir_code, 2'b11);
`else
      check("left_reject_pulses", rej_cnt, 0);
      check("left_code", dir_code, 2'b00);
`endif
      tick(4'b0001, 1'b1);
      repeat (10) tick(4'b0000, 1'b0);

      // Pending down, then up lands in the same cycle as an ack
      repeat (D + 5) tick(4'b0010, 1'b0);
      check("pend_down", dir_code, 2'b01);
      for (int k = 1; k <= D + 3; k++) tick(4'b0110, (k == D + 3));
`ifdef SNAKE_DIR_REVERSE_FILTER_EN
      check("ack_up_valid", dir_valid, 1'b0);
      check("ack_up_code", dir_code, 2'b01);
`else
      check("ack_up_valid", dir_valid, 1'b1);
      check("ack_up_code", dir_code, 2'b10);
`endif
      tick(4'b0110, 1'b1);
      repeat (10) tick(4'b0000, 1'b0);

      // Reset mid-debounce, button held across release
      repeat (3) tick(4'b1000, 1'b0);
      pulse_reset();
      repeat (20) tick(4'b1000, 1'b0);
      check("held_through_reset", dir_valid, 1'b0);
      repeat (10) tick(4'b0000, 1'b0);
      repeat (D + 5) tick(4'b1000, 1'b0);
      check("repress_valid", dir_valid, 1'b1);
      check("repress_code", dir_code, 2'b11);

      // Reset with a request pending
      pulse_reset();
      check("pending_reset_valid", dir_valid, 1'b0);
      repeat (10) tick(4'b0000, 1'b0);

      // Randomized stimulus against the model
      for (int r = 0; r < 300; r++) begin
         case ($urandom_range(0, 3))
            0:       rb = 4'b0000;
            1:       rb = 4'($urandom);
            default: rb = 4'(1 << $urandom_range(0, 3));
         endcase
         hold = $urandom_range(1, 2 * D + 4);
         for (int h = 0; h < hold; h++) tick(rb, ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 60) == 0) pulse_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
